golden_nonce_scheduler: RTL and testbench
=========================================

# golden_nonce_scheduler

Shares the single serial TX word path between `NUM_CORES` hashing cores reporting golden nonces. Each core's result is captured in a per-core holding register, a round-robin arbiter moves captured nonces into a shared FIFO, and a launch FSM feeds the FIFO head to the serial core's `word`/`tx_ready` input, one 32-bit word per transmission. The block sits between the hasher array and the serial core. A flush input discards stale results when new work arrives.

## Interface
- `NUM_CORES`, 4: number of requesting hash cores, 1–16
- `FIFO_DEPTH`, 8: nonce FIFO entries, power of two, ≥2
- `clk`  in  1  system clock, same domain as the serial core
- `rst_n`  in  1  asynchronous, active-low reset
- `nonce_valid`  in  NUM_CORES  one-cycle strobe per core
- `nonce_in`  in  32*NUM_CORES  nonce for core i at bits [32i+31:32i]
- `flush`  in  1  one-cycle pulse when a new work packet completes
- `tx_busy`  in  1  serial core busy flag
- `tx_ready`  out  1  one-cycle launch strobe to the serial core
- `word`  out  32  nonce to send; stable whenever `tx_ready`=1
- `fifo_empty`  out  1  FIFO holds no entries
- `drop_count`  out  8  saturating count of nonces lost to overflow

## Operation
- Reset values: `tx_ready`=0, `word`=0, `fifo_empty`=1, `drop_count`=0. Holding registers are empty, round-robin pointer=0, FSM is in IDLE.
- Capture: `nonce_valid[i]` with hold[i] empty loads hold[i].
  - A strobe with hold[i] full is still accepted if hold[i] is granted in the same cycle.
  - Otherwise the strobe is dropped and `drop_count`+1, saturating at 255.
- Arbiter: each cycle the FIFO is not full, it grants the first full hold at or after the pointer, wrapping modulo `NUM_CORES`.
  - The grant writes the nonce into the FIFO and empties that hold.
  - The pointer then moves to grant+1 mod `NUM_CORES`.
  - When the FIFO is full, no grant occurs and holds retain their values.
- Launch FSM:
  - IDLE: on FIFO non-empty and `tx_busy`=0, register `word`=head, pulse `tx_ready` for one cycle, pop the head, go to WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy`=1, go to WAIT_DONE. If `tx_busy` does not rise within 2 cycles, go to WAIT_DONE anyway; this is a lost launch and the word is not retried.
  - WAIT_DONE: on `tx_busy`=0, go to IDLE.
- Flush: clears all holds and the FIFO and resets the pointer to 0. Strobes arriving in the same cycle as `flush` are discarded and not counted. An in-flight launch (WAIT_BUSY or WAIT_DONE) completes normally. `drop_count` is unaffected.
- Push and pop in the same cycle are both allowed, and the FIFO count is unchanged.

## Timing
- `nonce_valid` in cycle N, with everything empty and `tx_busy`=0:
  - hold loaded at end of N
  - FIFO write at end of N+1
  - `tx_ready`=1 during N+3
- Back-to-back words: the next `tx_ready` comes no earlier than 1 cycle after `tx_busy` falls.
- `tx_ready` is never high in two consecutive cycles and never high while `tx_busy`=1.
- Arbiter throughput is one nonce per cycle. All outputs are registered.

## Configuration
- `GOLDEN_NONCE_DEDUP_EN` defined: a granted nonce equal to the last nonce written to the FIFO is discarded. It is not counted as a drop. The compare register resets to 0 and is cleared by `flush`.
- Not defined: every granted nonce is enqueued and there is no compare register.

## Structure
- Package `golden_nonce_pkg` holds:
  - FSM state encoding (IDLE, WAIT_BUSY, WAIT_DONE)
  - `NONCE_W`=32
  - `DROP_CNT_W`=8
  - `BUSY_TIMEOUT`=2
- Sub-module `nonce_fifo`: synchronous FIFO with width `NONCE_W` and depth `FIFO_DEPTH`. It provides a count, full/empty flags, a flush input and first-word-fall-through head.

## Test plan
- Single nonce 0xDEADBEEF on core 2 at cycle 10, `tx_busy` held low until `tx_ready`, then high for 40 cycles → `tx_ready` at cycle 13 with `word`=0xDEADBEEF and exactly one launch.
- Cores 0–3 all strobe in the same cycle with nonces 0x10, 0x11, 0x12, 0x13 → transmitted in order 0x10, 0x11, 0x12, 0x13. A second burst after the pointer has advanced to 1 starts from core 1.
- `tx_busy` stuck high and core 0 strobes 10 distinct nonces, one every 3 cycles → FIFO fills to 8, hold 0 holds one, `drop_count`=1. After release, all 9 retained nonces are sent in order.
- `flush` asserted with 5 entries queued and a launch in WAIT_DONE → in-flight word completes, `fifo_empty`=1 next cycle, no further `tx_ready`.
- With `GOLDEN_NONCE_DEDUP_EN`: core 1 sends 0xCAFE0001 twice, then 0xCAFE0002 → exactly two words transmitted and `drop_count`=0.
- `rst_n` asserted during WAIT_DONE → all outputs return to reset values immediately, and after release no launch occurs until a new nonce arrives.

Source files
------------

// File: rtl/golden_nonce_pkg.sv
// Shared types and constants for the golden nonce scheduler.
package golden_nonce_pkg;

   localparam int NONCE_W      = 32;
   localparam int DROP_CNT_W   = 8;
   localparam int BUSY_TIMEOUT = 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } launch_state_e;

   // Up to 16 cores can lose a strobe in the same cycle, hence the 5-bit increment.
   function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                      input logic [4:0]            b);
      logic [DROP_CNT_W:0] s;
      s = {1'b0, a} + {{(DROP_CNT_W-4){1'b0}}, b};
      return s[DROP_CNT_W] ? '1 : s[DROP_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/golden_nonce_scheduler_fifo.sv
// Synchronous first-word-fall-through nonce FIFO with flush.
module nonce_fifo
   import golden_nonce_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [NONCE_W-1:0]         push_data_i,
   input  logic                       pop_i,
   output logic [NONCE_W-1:0]         head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [NONCE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [AW:0]        count_q;
   logic               do_push;
   logic               do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the count gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/golden_nonce_scheduler.sv
// Per-core nonce capture, round-robin arbitration into a FIFO, and serial TX launch FSM.
// Optional GOLDEN_NONCE_DEDUP_EN discards a granted nonce equal to the last one enqueued.
module golden_nonce_scheduler
   import golden_nonce_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CORES-1:0]          nonce_valid,
   input  logic [NONCE_W*NUM_CORES-1:0]  nonce_in,
   input  logic                          flush,
   input  logic                          tx_busy,
   output logic                          tx_ready,
   output logic [NONCE_W-1:0]            word,
   output logic                          fifo_empty,
   output logic [DROP_CNT_W-1:0]         drop_count
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   logic [NUM_CORES-1:0]  hold_full_q, hold_full_d;
   logic [NONCE_W-1:0]    hold_data_q [NUM_CORES];
   logic [NONCE_W-1:0]    hold_data_d [NUM_CORES];
   logic [PW-1:0]         ptr_q, ptr_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;
   logic [4:0]            drop_inc;

   logic                  grant_vld;
   logic [PW-1:0]         grant_idx;
   logic [PW-1:0]         cand;
   logic [NONCE_W-1:0]    grant_data;

   logic                  push;
   logic                  pop;
   logic                  launch;
   logic [NONCE_W-1:0]    fifo_head;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty_w;

   launch_state_e         state_q;
   logic                  tx_ready_q;
   logic [NONCE_W-1:0]    word_q;
   logic [TW-1:0]         tmo_q;

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (!fifo_full && !flush) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_CORES);
            if (!grant_vld && hold_full_q[cand]) begin
               grant_vld = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   assign grant_data = hold_data_q[grant_idx];

   // Grant is applied before capture so a full hold emptied this cycle can reload.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      drop_inc    = '0;
      if (flush) begin
         hold_full_d = '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_vld && grant_idx == PW'(i)) hold_full_d[i] = 1'b0;
            if (nonce_valid[i]) begin
               if (!hold_full_d[i]) begin
                  hold_full_d[i] = 1'b1;
                  hold_data_d[i] = nonce_in[i*NONCE_W +: NONCE_W];
               end else begin
                  drop_inc = drop_inc + 5'd1;
               end
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (flush)
         ptr_d = '0;
      else if (grant_vld)
         ptr_d = (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
   end

   assign drop_d = sat_add(drop_q, drop_inc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full_q <= '0;
         hold_data_q <= '{default: '0};
         ptr_q       <= '0;
         drop_q      <= '0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         ptr_q       <= ptr_d;
         drop_q      <= drop_d;
      end
   end

`ifdef GOLDEN_NONCE_DEDUP_EN
   logic [NONCE_W-1:0] last_q;

   assign push = grant_vld && (grant_data != last_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_q <= '0;
      else if (flush)
         last_q <= '0;
      else if (push)
         last_q <= grant_data;
   end
`else
   assign push = grant_vld;
`endif

   nonce_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (grant_data),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty_w)
   );

   assign launch = (state_q == ST_IDLE) && (fifo_count != '0) && !tx_busy && !flush;
   assign pop    = launch;

   // A launch whose busy never rises is abandoned after BUSY_TIMEOUT extra cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tx_ready_q <= 1'b0;
         word_q     <= '0;
         tmo_q      <= '0;
      end else begin
         tx_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (launch) begin
                  word_q     <= fifo_head;
                  tx_ready_q <= 1'b1;
                  tmo_q      <= '0;
                  state_q    <= ST_WAIT_BUSY;
               end
            end
            ST_WAIT_BUSY: begin
               if (tx_busy || tmo_q == TW'(BUSY_TIMEOUT))
                  state_q <= ST_WAIT_DONE;
               else
                  tmo_q <= tmo_q + 1'b1;
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_ready   = tx_ready_q;
   assign word       = word_q;
   assign fifo_empty = fifo_empty_w;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_scheduler.sv
// Directed bench for golden_nonce_scheduler: vector table plus multi-cycle corner sequences.
module tb_golden_nonce_scheduler;

   localparam int NC = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NC-1:0]    nonce_valid = '0;
   logic [32*NC-1:0] nonce_in = '0;
   logic             flush = 1'b0;
   logic             tx_busy = 1'b0;
   logic             tx_ready;
   logic [31:0]      word;
   logic             fifo_empty;
   logic [7:0]       drop_count;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int launch_cnt = 0;
   int last_launch_cyc = 0;
   int busy_len = 4;
   bit busy_force = 1'b0;
   logic [31:0] exp_q [$];

   typedef struct packed {
      logic [3:0]   mask;
      logic [127:0] n;
      logic [2:0]   cnt;
      logic [127:0] e;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   golden_nonce_scheduler #(
      .NUM_CORES  (NC),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .nonce_valid (nonce_valid),
      .nonce_in    (nonce_in),
      .flush       (flush),
      .tx_busy     (tx_busy),
      .tx_ready    (tx_ready),
      .word        (word),
      .fifo_empty  (fifo_empty),
      .drop_count  (drop_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Serial core model and launch scoreboard, evaluated mid-cycle.
   initial begin : serial_model
      int busy_cnt;
      bit prev_ready;
      busy_cnt = 0;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_cnt = 0;
            prev_ready = 1'b0;
         end else if (tx_ready) begin
            launch_cnt++;
            last_launch_cyc = cyc;
            check("launch_spacing", {30'd0, prev_ready, tx_busy}, 32'd0);
            check("launch_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_word", word, exp_q.pop_front());
            if (busy_len > 0) busy_cnt = busy_len;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
         end
         prev_ready = tx_ready;
         tx_busy = busy_force || (busy_cnt > 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [NC-1:0] mask, input logic [32*NC-1:0] nonces, output int s);
      @(negedge clk);
      s = cyc;
      nonce_valid = mask;
      nonce_in = nonces;
      @(negedge clk);
      nonce_valid = '0;
   endtask

   task automatic strobe_one(input int core, input logic [31:0] n);
      logic [32*NC-1:0] v;
      int s;
      v = '0;
      v[32*core +: 32] = n;
      strobe(NC'(1) << core, v, s);
   endtask

   task automatic pulse_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic wait_launch(input int target, input int budget, input string name);
      int t;
      t = 0;
      while (launch_cnt < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(launch_cnt), 32'(target));
   endtask

   task automatic wait_drain(input int budget, input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      idle(8);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int s;
      int base;

      vecs[0] = '{mask: 4'b1111, n: {32'h13, 32'h12, 32'h11, 32'h10}, cnt: 3'd4,
                  e: {32'h13, 32'h12, 32'h11, 32'h10}};
      vecs[1] = '{mask: 4'b0001, n: {32'hBAD3, 32'hBAD2, 32'hBAD1, 32'hA0}, cnt: 3'd1,
                  e: {32'h0, 32'h0, 32'h0, 32'hA0}};
      vecs[2] = '{mask: 4'b1111, n: {32'h23, 32'h22, 32'h21, 32'h20}, cnt: 3'd4,
                  e: {32'h20, 32'h23, 32'h22, 32'h21}};
      vecs[3] = '{mask: 4'b0101, n: {32'hBAD3, 32'h32, 32'hBAD1, 32'h30}, cnt: 3'd2,
                  e: {32'h0, 32'h0, 32'h30, 32'h32}};
      vecs[4] = '{mask: 4'b1010, n: {32'h43, 32'hBAD2, 32'h41, 32'hBAD0}, cnt: 3'd2,
                  e: {32'h0, 32'h0, 32'h43, 32'h41}};
      vecs[5] = '{mask: 4'b1100, n: {32'h53, 32'h52, 32'hBAD1, 32'hBAD0}, cnt: 3'd2,
                  e: {32'h0, 32'h0, 32'h53, 32'h52}};

      // Reset values
      @(negedge clk);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
      check("rst_word", word, 32'd0);
      check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
      check("rst_drop_count", {24'd0, drop_count}, 32'd0);
      idle(2);
      rst_n = 1'b1;

      // Single nonce on core 2 at cycle 10: launch three cycles later, exactly once
      while (cyc < 9) @(negedge clk);
      busy_len = 40;
      exp_q.push_back(32'hDEADBEEF);
      strobe(4'b0100, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, s);
      check("t1_strobe_cycle", 32'(s), 32'd10);
      wait_launch(1, 10, "t1_launch");
      check("t1_latency", 32'(last_launch_cyc - s), 32'd3);
      idle(48);
      check("t1_launch_count", 32'(launch_cnt), 32'd1);
      check("t1_fifo_empty", {31'd0, fifo_empty}, 32'd1);

      // Round-robin vectors, starting from pointer 0
      pulse_flush();
      busy_len = 4;
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < int'(vecs[v].cnt); k++) exp_q.push_back(vecs[v].e[32*k +: 32]);
         strobe(vecs[v].mask, vecs[v].n, s);
         wait_drain(100, $sformatf("vec%0d_drain", v));
      end
      check("vec_drop_count", {24'd0, drop_count}, 32'd0);

      // FIFO overflow with the serial core stuck busy
      busy_len = 3;
      busy_force = 1'b1;
      idle(1);
      base = launch_cnt;
      for (int j = 0; j < 10; j++) begin
         strobe_one(0, 32'h100 + 32'(j));
         idle(1);
      end
      idle(3);
      check("ovf_drop_count", {24'd0, drop_count}, 32'd1);
      check("ovf_fifo_empty", {31'd0, fifo_empty}, 32'd0);
      check("ovf_no_launch", 32'(launch_cnt - base), 32'd0);
      for (int j = 0; j < 9; j++) exp_q.push_back(32'h100 + 32'(j));
      busy_force = 1'b0;
      wait_drain(300, "ovf_drain");
      check("ovf_launches", 32'(launch_cnt - base), 32'd9);

      // Flush with five queued while a launch sits in WAIT_DONE
      busy_len = 30;
      base = launch_cnt;
      exp_q.push_back(32'h200);
      for (int j = 0; j < 6; j++) strobe_one(0, 32'h200 + 32'(j));
      check("fl_fifo_before", {31'd0, fifo_empty}, 32'd0);
      pulse_flush();
      check("fl_fifo_empty", {31'd0, fifo_empty}, 32'd1);
      idle(60);
      check("fl_launches", 32'(launch_cnt - base), 32'd1);
      check("fl_exp_done", 32'(exp_q.size()), 32'd0);
      exp_q.delete();

      // Lost launch: serial core never raises busy; first word is not retried
      busy_len = 0;
      base = launch_cnt;
      exp_q.push_back(32'h300);
      exp_q.push_back(32'h301);
      strobe(4'b0011, {32'h0, 32'h0, 32'h301, 32'h300}, s);
      wait_drain(50, "lost_drain");
      check("lost_launches", 32'(launch_cnt - base), 32'd2);

      // Asynchronous reset during WAIT_DONE with a queued entry
      busy_len = 20;
      base = launch_cnt;
      exp_q.push_back(32'h400);
      strobe_one(3, 32'h400);
      wait_launch(base + 1, 10, "rst_launch");
      strobe_one(0, 32'h401);
      idle(3);
      check("rst_pre_fifo", {31'd0, fifo_empty}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_tx_ready", {31'd0, tx_ready}, 32'd0);
      check("arst_word", word, 32'd0);
      check("arst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
      check("arst_drop_count", {24'd0, drop_count}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(30);
      check("arst_no_launch", 32'(launch_cnt - base), 32'd1);
      exp_q.push_back(32'h402);
      strobe_one(2, 32'h402);
      wait_drain(50, "arst_new_drain");
      check("arst_new_launch", 32'(launch_cnt - base), 32'd2);

      // Repeated nonce on core 1
      busy_len = 4;
      base = launch_cnt;
      exp_q.push_back(32'hCAFE0001);
`ifndef GOLDEN_NONCE_DEDUP_EN
      exp_q.push_back(32'hCAFE0001);
`endif
      exp_q.push_back(32'hCAFE0002);
      strobe_one(1, 32'hCAFE0001);
      idle(10);
      strobe_one(1, 32'hCAFE0001);
      idle(10);
      strobe_one(1, 32'hCAFE0002);
      wait_drain(100, "dup_drain");
`ifdef GOLDEN_NONCE_DEDUP_EN
      check("dup_launches", 32'(launch_cnt - base), 32'd2);
`else
      check("dup_launches", 32'(launch_cnt - base), 32'd3);
`endif
      check("dup_drop_count", {24'd0, drop_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
